// File: rtl/video_address_counter_if.sv
// ---------------------------------------------------------------------------
// video_address_counter_if
// Bus bundle between the VDG/SAM side and the video address counter.
//   DA0  : VDG address clock (asynchronous to OSCOut)
//   nHS  : VDG horizontal sync, active low (asynchronous to OSCOut)
//   V    : video mode from the SAM registers
//   F    : display offset, loaded into B[16:9] on vertical preset
//   B    : 17-bit video refresh address
//   VP   : one-cycle pulse in the cycle the vertical preset is applied
//   DMA  : high while V[2:0] selects DMA mode
// master drives the VDG/SAM inputs, slave is the counter itself.
// ---------------------------------------------------------------------------
interface video_address_counter_if;
    logic        DA0;
    logic        nHS;
    logic [3:0]  V;
    logic [7:0]  F;
    logic [16:0] B;
    logic        VP;
    logic        DMA;

    modport master (output DA0, output nHS, output V, output F,
                    input  B,   input  VP,  input  DMA);

    modport slave  (input  DA0, input  nHS, input  V,  input  F,
                    output B,   output VP,  output DMA);
endinterface

// File: rtl/video_address_counter.sv
// ---------------------------------------------------------------------------
// video_address_counter
// Generates the 17-bit video refresh address B[16:0] for the SAMx4 Z-address
// mapper. DA0 rising edges advance the address through mode-dependent X
// (horizontal) and Y (row-repeat) dividers; an nHS falling edge clears the
// column bits; a long DA0 high period (vertical blanking) presets the
// address from the display offset F.
//
// Ports:
//   OSCOut : master clock, all state on its rising edge
//   nRES   : asynchronous active-low reset
//   bus    : video_address_counter_if.slave (DA0, nHS, V, F in; B, VP, DMA out)
//
// Parameters:
//   PRESET_CYCLES : synchronised-high DA0 cycles that signal vertical preset
//
// Optional feature macro:
//   SAMX_YDIV8_EN : when defined, V==4'b1101 selects X/1, Y/8. When undefined
//                   V[3] is ignored completely.
// ---------------------------------------------------------------------------
module video_address_counter #(
    parameter int PRESET_CYCLES = 32
) (
    input  logic                    OSCOut,
    input  logic                    nRES,
    video_address_counter_if.slave  bus
);

    localparam int HI_W = $clog2(PRESET_CYCLES + 1);
    localparam logic [HI_W-1:0] HI_MAX  = HI_W'(PRESET_CYCLES);
    localparam logic [HI_W-1:0] HI_FIRE = HI_W'(PRESET_CYCLES - 1);

    // Synchroniser / edge-detect flops
    logic da0_meta_r, da0_sync_r, da0_prev_r;
    logic hs_meta_r,  hs_sync_r,  hs_prev_r;

    // Counter state
    logic [16:0]     b_r;
    logic [1:0]      xcnt_r;
    logic [3:0]      ycnt_r;
    logic [HI_W-1:0] da0_hi_cnt_r;
    logic            vp_r;
    logic [3:0]      mode_r;

    // Combinational helpers
    logic            da0_rise_s;
    logic            hs_fall_s;
    logic            preset_s;
    logic            ydiv8_sel_s;
    logic [3:0]      mode_s;
    logic            mode_change_s;
    logic            dma_s;
    logic [1:0]      nx_max_s;
    logic [3:0]      ny_max_s;
    logic [16:0]     adv_b_s;
    logic [1:0]      adv_xcnt_s;
    logic [3:0]      adv_ycnt_s;

`ifdef SAMX_YDIV8_EN
    assign ydiv8_sel_s = (bus.V == 4'b1101);
`else
    // V[3] carries no meaning in this build.
    logic unused_v3_s;
    assign unused_v3_s = bus.V[3];
    assign ydiv8_sel_s = 1'b0;
`endif

    // Effective mode: the ÷8 select is folded in so toggling into or out of
    // it counts as a mode change even though V[2:0] stays 101.
    assign mode_s        = {ydiv8_sel_s, bus.V[2:0]};
    assign mode_change_s = (mode_s != mode_r);
    assign dma_s         = (bus.V[2:0] == 3'b111);

    assign da0_rise_s = da0_sync_r & ~da0_prev_r;
    assign hs_fall_s  = ~hs_sync_r & hs_prev_r;

    // Fires in the one cycle the high-count steps onto PRESET_CYCLES; after
    // that the count sits saturated so the preset cannot repeat.
    assign preset_s   = da0_sync_r & (da0_hi_cnt_r == HI_FIRE);

    // Divider terminal values (N-1) per effective mode
    always_comb begin
        nx_max_s = 2'd0;
        ny_max_s = 4'd0;
        if (ydiv8_sel_s) begin
            nx_max_s = 2'd0;
            ny_max_s = 4'd7;
        end else begin
            case (bus.V[2:0])
                3'b000:  begin nx_max_s = 2'd0; ny_max_s = 4'd11; end
                3'b001:  begin nx_max_s = 2'd2; ny_max_s = 4'd0;  end
                3'b010:  begin nx_max_s = 2'd0; ny_max_s = 4'd2;  end
                3'b011:  begin nx_max_s = 2'd1; ny_max_s = 4'd0;  end
                3'b100:  begin nx_max_s = 2'd0; ny_max_s = 4'd1;  end
                default: begin nx_max_s = 2'd0; ny_max_s = 4'd0;  end
            endcase
        end
    end

    // Next address/divider state for a plain DA0 advance
    always_comb begin
        adv_b_s    = b_r;
        adv_xcnt_s = xcnt_r;
        adv_ycnt_s = ycnt_r;
        if (dma_s) begin
            adv_b_s = b_r + 17'd1;
        end else begin
            adv_b_s[3:0] = b_r[3:0] + 4'd1;
            if (b_r[3:0] == 4'hF) begin
                if (xcnt_r == nx_max_s) begin
                    adv_xcnt_s = 2'd0;
                    adv_b_s[4] = ~b_r[4];
                    // Only the 1->0 toggle of B4 carries into the Y divider.
                    if (b_r[4]) begin
                        if (ycnt_r == ny_max_s) begin
                            adv_ycnt_s    = 4'd0;
                            adv_b_s[16:5] = b_r[16:5] + 12'd1;
                        end else begin
                            adv_ycnt_s = ycnt_r + 4'd1;
                        end
                    end else begin
                        adv_ycnt_s = ycnt_r;
                    end
                end else begin
                    adv_xcnt_s = xcnt_r + 2'd1;
                end
            end else begin
                adv_xcnt_s = xcnt_r;
            end
        end
    end

    // Two-flop synchronisers plus edge-detect history for DA0 and nHS
    always_ff @(posedge OSCOut or negedge nRES) begin
        if (!nRES) begin
            da0_meta_r <= 1'b0;
            da0_sync_r <= 1'b0;
            da0_prev_r <= 1'b0;
            hs_meta_r  <= 1'b0;
            hs_sync_r  <= 1'b0;
            hs_prev_r  <= 1'b0;
        end else begin
            da0_meta_r <= bus.DA0;
            da0_sync_r <= da0_meta_r;
            da0_prev_r <= da0_sync_r;
            hs_meta_r  <= bus.nHS;
            hs_sync_r  <= hs_meta_r;
            hs_prev_r  <= hs_sync_r;
        end
    end

    // Saturating run-length count of synchronised DA0 high
    always_ff @(posedge OSCOut or negedge nRES) begin
        if (!nRES) begin
            da0_hi_cnt_r <= '0;
        end else if (!da0_sync_r) begin
            da0_hi_cnt_r <= '0;
        end else if (da0_hi_cnt_r != HI_MAX) begin
            da0_hi_cnt_r <= da0_hi_cnt_r + 1'b1;
        end
    end

    // Address and divider update with preset > hs_fall > mode change > da0_rise
    always_ff @(posedge OSCOut or negedge nRES) begin
        if (!nRES) begin
            b_r    <= 17'd0;
            xcnt_r <= 2'd0;
            ycnt_r <= 4'd0;
            vp_r   <= 1'b0;
            mode_r <= 4'd0;
        end else begin
            vp_r   <= preset_s;
            mode_r <= mode_s;
            if (preset_s) begin
                b_r    <= {bus.F, 9'd0};
                xcnt_r <= 2'd0;
                ycnt_r <= 4'd0;
            end else if (hs_fall_s) begin
                b_r[3:0] <= 4'd0;
                xcnt_r   <= 2'd0;
            end else if (mode_change_s) begin
                xcnt_r <= 2'd0;
                ycnt_r <= 4'd0;
            end else if (da0_rise_s) begin
                b_r    <= adv_b_s;
                xcnt_r <= adv_xcnt_s;
                ycnt_r <= adv_ycnt_s;
            end
        end
    end

    assign bus.B   = b_r;
    assign bus.VP  = vp_r;
    assign bus.DMA = dma_s;

endmodule

// File: tb/tb_video_address_counter.sv
// ---------------------------------------------------------------------------
// tb_video_address_counter
// Self-checking bench for video_address_counter. Directed scenarios plus
// randomised mode/offset/pulse-count trials checked against an arithmetic
// model of the address sequence.
// ---------------------------------------------------------------------------
module tb_video_address_counter;

    logic OSCOut = 1'b0;
    logic nRES   = 1'b0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 OSCOut = ~OSCOut;

    video_address_counter_if bus ();

    video_address_counter #(.PRESET_CYCLES(32)) dut (
        .OSCOut (OSCOut),
        .nRES   (nRES),
        .bus    (bus.slave)
    );

    // ---------------- reference model ----------------
    function automatic int model_nx(input logic [3:0] v);
        case (v[2:0])
            3'b001:  return 3;
            3'b011:  return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int model_ny(input logic [3:0] v);
`ifdef SAMX_YDIV8_EN
        if (v == 4'b1101) return 8;
`endif
        case (v[2:0])
            3'b000:  return 12;
            3'b010:  return 3;
            3'b100:  return 2;
            default: return 1;
        endcase
    endfunction

    // Address after n DA0 pulses from an aligned start (low 5 bits zero,
    // dividers at zero). Each B4 toggle needs 16*Nx pulses, each row step
    // needs two B4 toggles per Y count.
    function automatic logic [16:0] model_b(input logic [3:0] v, input logic [16:0] start, input int n);
        int k, rows;
        logic [16:0] r;
        if (v[2:0] == 3'b111) begin
            r = start + 17'(n);
            return r;
        end
        k    = n / (16 * model_nx(v));
        rows = (k / 2) / model_ny(v);
        r[3:0]  = 4'(n % 16);
        r[4]    = 1'(k % 2);
        r[16:5] = start[16:5] + 12'(rows);
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge OSCOut);
        #1;
    endtask

    task automatic pulses(input int n, input bit rnd);
        int hi, lo;
        for (int i = 0; i < n; i++) begin
            hi = rnd ? int'($urandom_range(2, 4)) : 3;
            lo = rnd ? int'($urandom_range(2, 4)) : 3;
            bus.DA0 = 1'b1;
            tick(hi);
            bus.DA0 = 1'b0;
            tick(lo);
        end
        tick(4);
    endtask

    task automatic do_reset(input logic [3:0] v);
        bus.V   = v;
        bus.DA0 = 1'b0;
        bus.nHS = 1'b1;
        nRES    = 1'b0;
        tick(2);
        nRES    = 1'b1;
        tick(3);
    endtask

    task automatic do_preset(input logic [7:0] f);
        bus.F   = f;
        bus.DA0 = 1'b1;
        tick(40);
        bus.DA0 = 1'b0;
        tick(4);
    endtask

    task automatic hs_fall();
        bus.nHS = 1'b0;
        tick(4);
        bus.nHS = 1'b1;
        tick(3);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.V = 4'b0000; bus.F = 8'h00; bus.DA0 = 1'b0; bus.nHS = 1'b1;
        nRES = 1'b0;
        tick(3);
        chk_cnt++; if (bus.B !== 17'h00000) $display("FAIL reset_b: got %h want 00000", bus.B); else pass_cnt++;
        chk_cnt++; if (bus.VP !== 1'b0) $display("FAIL reset_vp: got %b want 0", bus.VP); else pass_cnt++;
        chk_cnt++; if (bus.DMA !== 1'b0) $display("FAIL reset_dma0: got %b want 0", bus.DMA); else pass_cnt++;
        bus.V = 4'b0111;
        #1;
        chk_cnt++; if (bus.DMA !== 1'b1) $display("FAIL reset_dma1: got %b want 1", bus.DMA); else pass_cnt++;
        bus.V = 4'b0000;
        nRES = 1'b1;
        tick(3);
        chk_cnt++; if (bus.B !== 17'h00000) $display("FAIL post_reset_b: got %h want 00000", bus.B); else pass_cnt++;
    endtask

    task automatic test_y12();
        do_reset(4'b0000);
        pulses(16, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00010) $display("FAIL y12_16: got %h want 00010", bus.B); else pass_cnt++;
        pulses(368, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00020) $display("FAIL y12_384: got %h want 00020", bus.B); else pass_cnt++;
    endtask

    task automatic test_x3();
        do_reset(4'b0001);
        pulses(47, 1'b0);
        chk_cnt++; if (bus.B !== 17'h0000F) $display("FAIL x3_47: got %h want 0000F", bus.B); else pass_cnt++;
        pulses(1, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00010) $display("FAIL x3_48: got %h want 00010", bus.B); else pass_cnt++;
    endtask

    task automatic test_hs_clear();
        do_reset(4'b0101);
        pulses(10, 1'b0);
        chk_cnt++; if (bus.B !== 17'h0000A) $display("FAIL hs_pre: got %h want 0000A", bus.B); else pass_cnt++;
        hs_fall();
        chk_cnt++; if (bus.B !== 17'h00000) $display("FAIL hs_clr0: got %h want 00000", bus.B); else pass_cnt++;
        pulses(58, 1'b0);
        chk_cnt++; if (bus.B !== 17'h0003A) $display("FAIL hs_3a: got %h want 0003A", bus.B); else pass_cnt++;
        hs_fall();
        chk_cnt++; if (bus.B !== 17'h00030) $display("FAIL hs_clr30: got %h want 00030", bus.B); else pass_cnt++;
    endtask

    task automatic test_preset();
        int vp_cnt = 0;
        int first  = -1;
        logic [16:0] b_at = 17'h0;
        do_reset(4'b0101);
        bus.F   = 8'h0C;
        bus.DA0 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (bus.VP === 1'b1) begin
                vp_cnt++;
                if (first < 0) begin first = i; b_at = bus.B; end
            end
        end
        chk_cnt++; if (vp_cnt !== 1) $display("FAIL preset_vp_cnt: got %0d want 1", vp_cnt); else pass_cnt++;
        chk_cnt++; if (first !== 34) $display("FAIL preset_latency: got %0d want 34", first); else pass_cnt++;
        chk_cnt++; if (b_at !== 17'h01800) $display("FAIL preset_b: got %h want 01800", b_at); else pass_cnt++;
        bus.F  = 8'h55;
        vp_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus.VP === 1'b1) vp_cnt++;
        end
        chk_cnt++; if (vp_cnt !== 0) $display("FAIL preset_repeat: got %0d pulses want 0", vp_cnt); else pass_cnt++;
        bus.DA0 = 1'b0;
        tick(4);
        chk_cnt++; if (bus.B !== 17'h01800) $display("FAIL preset_f_ignored: got %h want 01800", bus.B); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset(4'b0101);
        do_preset(8'hFF);
        chk_cnt++; if (bus.B !== 17'h1FE00) $display("FAIL wrap_preset: got %h want 1FE00", bus.B); else pass_cnt++;
        pulses(512, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00000) $display("FAIL wrap_512: got %h want 00000", bus.B); else pass_cnt++;
    endtask

    task automatic test_dma();
        do_reset(4'b0111);
        chk_cnt++; if (bus.DMA !== 1'b1) $display("FAIL dma_flag: got %b want 1", bus.DMA); else pass_cnt++;
        do_preset(8'hFF);
        pulses(511, 1'b0);
        chk_cnt++; if (bus.B !== 17'h1FFFF) $display("FAIL dma_max: got %h want 1FFFF", bus.B); else pass_cnt++;
        pulses(1, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00000) $display("FAIL dma_wrap: got %h want 00000", bus.B); else pass_cnt++;
    endtask

    task automatic test_ydiv8();
        logic [16:0] exp;
`ifdef SAMX_YDIV8_EN
        exp = 17'h00020;
`else
        exp = 17'h00100;
`endif
        do_reset(4'b1101);
        pulses(256, 1'b0);
        chk_cnt++; if (bus.B !== exp) $display("FAIL ydiv8: got %h want %h", bus.B, exp); else pass_cnt++;
    endtask

    task automatic test_coincident();
        do_reset(4'b0101);
        pulses(21, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00015) $display("FAIL coin_pre: got %h want 00015", bus.B); else pass_cnt++;
        bus.DA0 = 1'b1;
        bus.nHS = 1'b0;
        tick(3);
        bus.DA0 = 1'b0;
        tick(3);
        bus.nHS = 1'b1;
        tick(4);
        chk_cnt++; if (bus.B !== 17'h00010) $display("FAIL coin_clear: got %h want 00010", bus.B); else pass_cnt++;
        pulses(1, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00011) $display("FAIL coin_next: got %h want 00011", bus.B); else pass_cnt++;
    endtask

    task automatic test_mode_change();
        do_reset(4'b0001);
        pulses(16, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00000) $display("FAIL mc_x3_16: got %h want 00000", bus.B); else pass_cnt++;
        bus.V = 4'b0011;
        tick(3);
        pulses(16, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00000) $display("FAIL mc_x2_16: got %h want 00000", bus.B); else pass_cnt++;
        pulses(16, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00010) $display("FAIL mc_x2_32: got %h want 00010", bus.B); else pass_cnt++;
    endtask

    task automatic test_reset_midcount();
        do_reset(4'b0101);
        pulses(20, 1'b0);
        bus.DA0 = 1'b1;
        tick(1);
        nRES = 1'b0;
        #1;
        chk_cnt++; if (bus.B !== 17'h00000) $display("FAIL midreset_b: got %h want 00000", bus.B); else pass_cnt++;
        bus.DA0 = 1'b0;
        tick(2);
        nRES = 1'b1;
        tick(3);
        pulses(3, 1'b0);
        chk_cnt++; if (bus.B !== 17'h00003) $display("FAIL midreset_after: got %h want 00003", bus.B); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [3:0]  modes [10];
        logic [3:0]  v;
        logic [7:0]  f;
        logic [16:0] start, exp;
        int          n;
        modes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                  4'b0101, 4'b0110, 4'b0111, 4'b1101, 4'b1001};
        for (int t = 0; t < 8; t++) begin
            v = modes[$urandom_range(0, 9)];
            do_reset(v);
            start = 17'h0;
            if ($urandom_range(0, 1) == 1) begin
                f = 8'($urandom_range(0, 255));
                do_preset(f);
                start = {f, 9'd0};
            end
            n = int'($urandom_range(0, 400));
            pulses(n, 1'b1);
            exp = model_b(v, start, n);
            chk_cnt++;
            if (bus.B !== exp)
                $display("FAIL rand_%0d (V=%b start=%h n=%0d): got %h want %h", t, v, start, n, bus.B, exp);
            else
                pass_cnt++;
        end
    endtask

    initial begin
        bus.DA0 = 1'b0;
        bus.nHS = 1'b1;
        bus.V   = 4'b0000;
        bus.F   = 8'h00;
        test_reset();
        test_y12();
        test_x3();
        test_hs_clear();
        test_preset();
        test_wrap();
        test_dma();
        test_ydiv8();
        test_coincident();
        test_mode_change();
        test_reset_midcount();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
